mysystem_nios2_jtag_cmd_sync: RTL and testbench



---
 rtl/mysystem_nios2_jtag_pkg.sv | 27 ++
 rtl/mysystem_nios2_jtag_edge_sync.sv | 40 ++++
 rtl/mysystem_nios2_jtag_cmd_sync.sv | 157 +++++++++++++++
 tb/tb_mysystem_nios2_jtag_cmd_sync.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mysystem_nios2_jtag_pkg.sv
//------------------------------------------------------------------------------
// Module  : mysystem_nios2_jtag_pkg
// Brief   : Shared types, default parameters and helpers for the JTAG cmd sync.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mysystem_nios2_jtag_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam int C_IR_W        = 2;
  localparam int C_DR_W        = 38;
  localparam int C_ACT_BIT     = 34;
  localparam int C_SYNC_STAGES = 2;
  localparam int C_CNT_W       = 8;

  function automatic int n_ch(input int ir_w);
    return 1 << ir_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mysystem_nios2_jtag_edge_sync.sv
//------------------------------------------------------------------------------
// Module  : mysystem_nios2_jtag_edge_sync
// Brief   : Level synchroniser with registered, arm-gated rising-edge flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mysystem_nios2_jtag_edge_sync
  import mysystem_nios2_jtag_pkg::*;
#(
  parameter int SYNC_STAGES = C_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  input  logic armed,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], level};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= armed & r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/mysystem_nios2_jtag_cmd_sync.sv
//------------------------------------------------------------------------------
// Module  : mysystem_nios2_jtag_cmd_sync
// Brief   : clk-side JTAG command receiver: strobe sync, one-entry hold, pulses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mysystem_nios2_jtag_cmd_sync
  import mysystem_nios2_jtag_pkg::*;
#(
  parameter int IR_W        = C_IR_W,
  parameter int DR_W        = C_DR_W,
  parameter int ACT_BIT     = C_ACT_BIT,
  parameter int SYNC_STAGES = C_SYNC_STAGES,
  parameter int CNT_W       = C_CNT_W,
  localparam int N_CH       = n_ch(IR_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vs_uir,
  input  logic             vs_udr,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [DR_W-1:0]  sr,
  input  logic             cmd_ready,
  input  logic             overrun_clr,
  output logic             cmd_valid,
  output logic [IR_W-1:0]  cmd_ir,
  output logic [DR_W-1:0]  jdo,
  output logic [N_CH-1:0]  take_action,
  output logic [N_CH-1:0]  take_no_action,
  output logic             overrun,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);

  logic [ARM_W-1:0] r_arm_cnt;
  logic             w_armed;
  logic             w_uir_rise;
  logic             w_udr_rise;
  logic [IR_W-1:0]  r_ir_lat;

  state_t           r_state,  w_state_nxt;
  logic [IR_W-1:0]  r_cmd_ir, w_cmd_ir_nxt;
  logic [DR_W-1:0]  r_jdo,    w_jdo_nxt;
  logic [N_CH-1:0]  r_act,    w_act_nxt;
  logic [N_CH-1:0]  r_nact,   w_nact_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [N_CH-1:0]  w_onehot;
  logic             w_accept;

  // Suppresses edges from strobes that were already high when reset released.
  assign w_armed = (r_arm_cnt == ARM_W'(SYNC_STAGES + 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  mysystem_nios2_jtag_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (vs_uir),
    .armed   (w_armed),
    .rise    (w_uir_rise)
  );

  mysystem_nios2_jtag_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (vs_udr),
    .armed   (w_armed),
    .rise    (w_udr_rise)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_lat <= '0;
    end else if (w_uir_rise) begin
      r_ir_lat <= ir_in;
    end
  end

  assign w_onehot = N_CH'(1) << r_cmd_ir;

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_ir_nxt  = r_cmd_ir;
    w_jdo_nxt     = r_jdo;
    w_act_nxt     = '0;
    w_nact_nxt    = '0;
    w_overrun_nxt = r_overrun & ~overrun_clr;
    w_cnt_nxt     = r_cnt;
    w_accept      = (r_state == ST_PEND) & cmd_ready;
    case (r_state)
      ST_IDLE: begin
        if (w_udr_rise) begin
          w_jdo_nxt    = sr;
          w_cmd_ir_nxt = r_ir_lat;
          w_state_nxt  = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_accept) begin
          if (r_jdo[ACT_BIT]) w_act_nxt  = w_onehot;
          else                w_nact_nxt = w_onehot;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          // A capture coinciding with an accept refills the buffer cleanly.
          if (w_udr_rise) begin
            w_jdo_nxt    = sr;
            w_cmd_ir_nxt = r_ir_lat;
          end else begin
            w_state_nxt  = ST_IDLE;
          end
        end else if (w_udr_rise) begin
          w_overrun_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cmd_ir  <= '0;
      r_jdo     <= '0;
      r_act     <= '0;
      r_nact    <= '0;
      r_overrun <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_ir  <= w_cmd_ir_nxt;
      r_jdo     <= w_jdo_nxt;
      r_act     <= w_act_nxt;
      r_nact    <= w_nact_nxt;
      r_overrun <= w_overrun_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign cmd_valid      = (r_state == ST_PEND);
  assign cmd_ir         = r_cmd_ir;
  assign jdo            = r_jdo;
  assign take_action    = r_act;
  assign take_no_action = r_nact;
  assign overrun        = r_overrun;
  assign cmd_count      = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mysystem_nios2_jtag_cmd_sync.sv
//------------------------------------------------------------------------------
// Module  : tb_mysystem_nios2_jtag_cmd_sync
// Brief   : Directed bench with pulse scoreboard for the JTAG command receiver.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mysystem_nios2_jtag_cmd_sync;

  typedef struct packed {
    logic [3:0] act;
    logic [3:0] nact;
  } exp_t;

  localparam logic [37:0] C_DATA_A = 38'h05A5A51234; // bit34 = 1
  localparam logic [37:0] C_DATA_B = 38'h3B12345678; // bit34 = 0
  localparam logic [37:0] C_DATA_C = 38'h1FFFFFFFFF;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration
  logic        reset_n, vs_uir, vs_udr, cmd_ready, overrun_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, overrun;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic [7:0]  cmd_count;

  // wide-IR, narrow-counter configuration
  logic        reset_n1, vs_uir1, vs_udr1, cmd_ready1, overrun_clr1;
  logic [2:0]  ir_in1;
  logic [19:0] sr1;
  logic        cmd_valid1, overrun1;
  logic [2:0]  cmd_ir1;
  logic [19:0] jdo1;
  logic [7:0]  take_action1, take_no_action1;
  logic [1:0]  cmd_count1;

  mysystem_nios2_jtag_cmd_sync dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .overrun_clr    (overrun_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .overrun        (overrun),
    .cmd_count      (cmd_count)
  );

  mysystem_nios2_jtag_cmd_sync #(
    .IR_W(3), .DR_W(20), .ACT_BIT(19), .SYNC_STAGES(2), .CNT_W(2)
  ) dut1 (
    .clk            (clk),
    .reset_n        (reset_n1),
    .vs_uir         (vs_uir1),
    .vs_udr         (vs_udr1),
    .ir_in          (ir_in1),
    .sr             (sr1),
    .cmd_ready      (cmd_ready1),
    .overrun_clr    (overrun_clr1),
    .cmd_valid      (cmd_valid1),
    .cmd_ir         (cmd_ir1),
    .jdo            (jdo1),
    .take_action    (take_action1),
    .take_no_action (take_no_action1),
    .overrun        (overrun1),
    .cmd_count      (cmd_count1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_ir(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    tick(4);
  endtask

  task automatic send_dr(input logic [37:0] data);
    sr     = data;
    vs_udr = 1'b1;
    tick(6);
    vs_udr = 1'b0;
    tick(4);
  endtask

  task automatic send_dr1(input logic [19:0] data);
    sr1     = data;
    vs_udr1 = 1'b1;
    tick(4);
    vs_udr1 = 1'b0;
    tick(4);
  endtask

  // Scoreboard: every pulse on the default instance must match the oldest expectation.
  always @(negedge clk) begin
    if ((take_action | take_no_action) != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {56'd0, take_action, take_no_action}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_act",  {60'd0, take_action},    {60'd0, e.act});
        check("pulse_nact", {60'd0, take_no_action}, {60'd0, e.nact});
      end
    end
  end

  initial begin
    reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; overrun_clr = 1'b0;
    reset_n1 = 1'b0; vs_uir1 = 1'b0; vs_udr1 = 1'b0; ir_in1 = '0; sr1 = '0;
    cmd_ready1 = 1'b0; overrun_clr1 = 1'b0;
    tick(3);
    check("rst_valid",   {63'd0, cmd_valid}, 64'd0);
    check("rst_jdo",     {26'd0, jdo}, 64'd0);
    check("rst_count",   {56'd0, cmd_count}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
    check("rst_cmd_ir",  {62'd0, cmd_ir}, 64'd0);
    reset_n = 1'b1; reset_n1 = 1'b1;
    tick(5);

    // Action and no-action commands with the consumer always ready.
    cmd_ready = 1'b1;
    send_ir(2'd2);
    exp_q.push_back('{act: 4'b0100, nact: 4'b0000});
    send_dr(C_DATA_A);
    check("t1_jdo",   {26'd0, jdo}, {26'd0, C_DATA_A});
    check("t1_count", {56'd0, cmd_count}, 64'd1);
    check("t1_valid", {63'd0, cmd_valid}, 64'd0);
    exp_q.push_back('{act: 4'b0000, nact: 4'b0100});
    send_dr(C_DATA_B);
    check("t1b_jdo",   {26'd0, jdo}, {26'd0, C_DATA_B});
    check("t1b_count", {56'd0, cmd_count}, 64'd2);

    // Overrun: second command dropped while the first is held.
    cmd_ready = 1'b0;
    send_dr(C_DATA_A);
    check("t2_valid",    {63'd0, cmd_valid}, 64'd1);
    check("t2_overrun0", {63'd0, overrun}, 64'd0);
    send_dr(C_DATA_B);
    check("t2_jdo",      {26'd0, jdo}, {26'd0, C_DATA_A});
    check("t2_overrun1", {63'd0, overrun}, 64'd1);
    check("t2_cmd_ir",   {62'd0, cmd_ir}, 64'd2);
    exp_q.push_back('{act: 4'b0100, nact: 4'b0000});
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    tick(1);
    check("t2_count",    {56'd0, cmd_count}, 64'd3);
    check("t2_valid_lo", {63'd0, cmd_valid}, 64'd0);
    check("t2_sticky",   {63'd0, overrun}, 64'd1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("t2_clr",      {63'd0, overrun}, 64'd0);

    // Accept coincides with the next capture.
    send_dr(C_DATA_A);
    sr     = C_DATA_B;
    vs_udr = 1'b1;
    tick(3);
    exp_q.push_back('{act: 4'b0100, nact: 4'b0000});
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("t3_valid",   {63'd0, cmd_valid}, 64'd1);
    check("t3_jdo",     {26'd0, jdo}, {26'd0, C_DATA_B});
    check("t3_overrun", {63'd0, overrun}, 64'd0);
    vs_udr = 1'b0;
    tick(4);
    exp_q.push_back('{act: 4'b0000, nact: 4'b0100});
    cmd_ready = 1'b1;
    tick(2);
    cmd_ready = 1'b0;
    check("t3_count",   {56'd0, cmd_count}, 64'd5);

    // Strobe already high across reset release must not create a command.
    reset_n = 1'b0;
    sr      = C_DATA_C;
    vs_udr  = 1'b1;
    tick(2);
    check("t4_rst_count", {56'd0, cmd_count}, 64'd0);
    reset_n   = 1'b1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("t4_no_valid", {63'd0, cmd_valid}, 64'd0);
    end
    check("t4_count", {56'd0, cmd_count}, 64'd0);
    vs_udr    = 1'b0;
    cmd_ready = 1'b0;
    tick(4);

    // IR update while a command is held does not disturb its channel.
    send_ir(2'd1);
    send_dr(C_DATA_A);
    check("t5_cmd_ir", {62'd0, cmd_ir}, 64'd1);
    send_ir(2'd3);
    check("t5_cmd_ir_held", {62'd0, cmd_ir}, 64'd1);
    check("t5_valid",       {63'd0, cmd_valid}, 64'd1);
    exp_q.push_back('{act: 4'b0010, nact: 4'b0000});
    cmd_ready = 1'b1;
    tick(2);
    exp_q.push_back('{act: 4'b0000, nact: 4'b1000});
    send_dr(C_DATA_B);
    cmd_ready = 1'b0;
    check("t5_count", {56'd0, cmd_count}, 64'd2);
    tick(2);
    check("pending_pulses", 64'(exp_q.size()), 64'd0);

    // Wide IR, high action bit, narrow counter.
    ir_in1  = 3'd7;
    vs_uir1 = 1'b1;
    tick(4);
    vs_uir1 = 1'b0;
    tick(4);
    send_dr1(20'h81357);
    check("w_valid", {63'd0, cmd_valid1}, 64'd1);
    check("w_cmd_ir", {61'd0, cmd_ir1}, 64'd7);
    cmd_ready1 = 1'b1;
    tick(1);
    cmd_ready1 = 1'b0;
    check("w_act",  {56'd0, take_action1}, 64'h80);
    check("w_nact", {56'd0, take_no_action1}, 64'd0);
    tick(1);
    check("w_act_once", {56'd0, take_action1}, 64'd0);
    cmd_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) send_dr1(20'($urandom));
    cmd_ready1 = 1'b0;
    check("w_count_wrap", {62'd0, cmd_count1}, 64'd1);

    send_dr1(20'h81357);
    check("w_pend", {63'd0, cmd_valid1}, 64'd1);
    reset_n1 = 1'b0;
    #1;
    check("w_rst_outs",
          {cmd_valid1, overrun1, cmd_ir1, cmd_count1, take_action1, take_no_action1, jdo1},
          64'd0);
    tick(1);
    check("w_rst_jdo", {44'd0, jdo1}, 64'd0);
    reset_n1 = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
